// File: rtl/map_read_arbiter.sv
// Round-robin arbiter that shares the map ROM game-logic read port among
// NUM_REQ requesters, with a fully pipelined tag path to route responses.
// Define MAP_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module map_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_col_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_row_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [7:0]                 rsp_data_o,
  output logic [ADDR_W-1:0]          map_col_addr_o,
  output logic [ADDR_W-1:0]          map_row_addr_o,
  input  logic [7:0]                 map_data_i,
  output logic                       idle_o
);

  localparam int ID_W = 3;
  localparam int LAST = READ_LATENCY;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;

`ifdef MAP_ARB_FIXED_PRIORITY_EN
  // Descending scan so the lowest asserted index is the final assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    if (reset_i) grant_vld = 1'b0;
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Search ptr+1, ptr+2, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_valid_i[i] && (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
    if (reset_i) grant_vld = 1'b0;
  end

  assign ptr_d = grant_vld ? grant_idx : ptr_q;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    if (reset_i) ptr_q <= ID_W'(NUM_REQ - 1);
    else         ptr_q <= ptr_d;
  end
`endif

  logic [ADDR_W-1:0] sel_col, sel_row;

  always_comb begin
    req_ready_o = '0;
    sel_col     = '0;
    sel_row     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready_o[i] = grant_vld;
        sel_col        = req_col_i[i*ADDR_W +: ADDR_W];
        sel_row        = req_row_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  logic [ADDR_W-1:0] map_col_q, map_col_d;
  logic [ADDR_W-1:0] map_row_q, map_row_d;
  logic [LAST:0]     tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]   tag_id_q [0:LAST];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;

  assign map_col_d   = grant_vld ? sel_col : map_col_q;
  assign map_row_d   = grant_vld ? sel_row : map_row_q;
  assign tag_valid_d = {tag_valid_q[LAST-1:0], grant_vld};

  // The last tag stage lines up with map_data for the read it describes.
  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tag_valid_q[LAST] && (tag_id_q[LAST] == ID_W'(i));
    end
    rsp_data_d = tag_valid_q[LAST] ? map_data_i : rsp_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      map_col_q   <= '0;
      map_row_q   <= '0;
      tag_valid_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      map_col_q   <= map_col_d;
      map_row_q   <= map_row_d;
      tag_valid_q <= tag_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // NOTE: tag ids are only meaningful under tag_valid_q, so this pipe carries no reset.
  always_ff @(posedge clk_i) begin
    tag_id_q[0] <= grant_idx;
    for (int s = 1; s <= LAST; s++) begin
      tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  assign map_col_addr_o = map_col_q;
  assign map_row_addr_o = map_row_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign idle_o         = ~|tag_valid_q & ~|req_valid_i;

endmodule

// File: tb/tb_map_read_arbiter.sv
// Directed bench for map_read_arbiter: one latency-1 instance for the main
// scenarios plus a latency-3 instance for the deeper tag pipe.
module tb_map_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [19:0] req_col, req_row;
  logic [7:0]  rsp_data, map_data;
  logic [9:0]  map_col, map_row;
  logic        idle;

  logic [1:0]  req_valid_l3, req_ready_l3, rsp_valid_l3;
  logic [19:0] req_col_l3, req_row_l3;
  logic [7:0]  rsp_data_l3, map_data_l3, m1, m2, m3;
  logic [9:0]  map_col_l3, map_row_l3;
  logic        idle_l3;

  int n_cmp = 0;
  int n_bad = 0;

  map_read_arbiter #(.NUM_REQ(2), .READ_LATENCY(1), .ADDR_W(10)) u_dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_col_i(req_col),
    .req_row_i(req_row), .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .map_col_addr_o(map_col), .map_row_addr_o(map_row),
    .map_data_i(map_data), .idle_o(idle));

  map_read_arbiter #(.NUM_REQ(2), .READ_LATENCY(3), .ADDR_W(10)) u_dut_l3 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid_l3), .req_col_i(req_col_l3),
    .req_row_i(req_row_l3), .req_ready_o(req_ready_l3), .rsp_valid_o(rsp_valid_l3),
    .rsp_data_o(rsp_data_l3), .map_col_addr_o(map_col_l3), .map_row_addr_o(map_row_l3),
    .map_data_i(map_data_l3), .idle_o(idle_l3));

  // Map ROM model: one special WIN-like cell, otherwise col^row low bytes.
  function automatic logic [7:0] pix(input logic [9:0] c, input logic [9:0] r);
    if (c == 10'h217 && r == 10'h0F7) return 8'h26;
    return c[7:0] ^ r[7:0];
  endfunction

  always @(posedge clk) map_data <= pix(map_col, map_row);
  always @(posedge clk) begin
    m1 <= pix(map_col_l3, map_row_l3);
    m2 <= m1;
    m3 <= m2;
  end
  assign map_data_l3 = m3;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    req_col = '0;
    req_row = '0;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    cyc();
    cyc();
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready_held: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    n_cmp++; if (map_col !== 10'h000 || map_row !== 10'h000) begin n_bad++; $display("FAIL reset_map_addr: got %h/%h want 000/000", map_col, map_row); end
    n_cmp++; if (rsp_valid_l3 !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid_l3: got %b want 00", rsp_valid_l3); end
    req_valid = 2'b00;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    req_col[9:0] = 10'h20F;
    req_row[9:0] = 10'h0FE;
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    n_cmp++; if (map_col !== 10'h20F || map_row !== 10'h0FE) begin n_bad++; $display("FAIL single_map_addr: got %h/%h want 20f/0fe", map_col, map_row); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL single_busy: got idle=%b want 0", idle); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL single_rsp_t1: got %b want 00", rsp_valid); end
    cyc();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL single_rsp_t2: got %b want 00", rsp_valid); end
    cyc();
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== 8'hF1) begin n_bad++; $display("FAIL single_rsp_t3: got %b/%h want 01/f1", rsp_valid, rsp_data); end
    cyc();
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_data !== 8'hF1) begin n_bad++; $display("FAIL single_rsp_hold: got %b/%h want 00/f1", rsp_valid, rsp_data); end
    n_cmp++; if (idle !== 1'b1 || map_col !== 10'h20F) begin n_bad++; $display("FAIL single_idle_hold: got idle=%b col=%h want 1/20f", idle, map_col); end
  endtask

  task automatic test_req1_pixel();
    req_col[19:10] = 10'h217;
    req_row[19:10] = 10'h0F7;
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL req1_ready: got %b want 10", req_ready); end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      req_valid = 2'b00;
      n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL req1_no_rsp0 cyc%0d: got %b want 0", i, rsp_valid[0]); end
      if (i == 3) begin
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h26) begin n_bad++; $display("FAIL req1_rsp: got %b/%h want 10/26", rsp_valid, rsp_data); end
      end
    end
  endtask

  task automatic load_pair();
    req_col = {10'h123, 10'h010};
    req_row = {10'h045, 10'h005};
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic [7:0] exp_d;
    load_pair();
    for (int i = 0; i <= 9; i++) begin
      if (i >= 1 && i <= 6) begin
        n_cmp++;
        if (map_col !== (((i - 1) % 2 == 0) ? 10'h010 : 10'h123)) begin
          n_bad++; $display("FAIL rr_map_col cyc%0d: got %h", i, map_col);
        end
      end
      if (i >= 3 && i <= 8) begin
        exp   = ((i - 3) % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = ((i - 3) % 2 == 0) ? 8'h15 : 8'h66;
        n_cmp++; if (rsp_valid !== exp || rsp_data !== exp_d) begin n_bad++; $display("FAIL rr_rsp cyc%0d: got %b/%h want %b/%h", i, rsp_valid, rsp_data, exp, exp_d); end
      end else begin
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rr_rsp_quiet cyc%0d: got %b want 00", i, rsp_valid); end
      end
      req_valid = (i < 6) ? 2'b11 : 2'b00;
      #1;
      if (i < 6) begin
        exp = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL rr_grant cyc%0d: got %b want %b", i, req_ready, exp); end
      end
      cyc();
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp;
    logic [7:0] exp_d;
    load_pair();
    for (int i = 0; i <= 9; i++) begin
      if (i >= 3 && i <= 7) begin
        exp   = (i <= 6) ? 2'b01 : 2'b10;
        exp_d = (i <= 6) ? 8'h15 : 8'h66;
        n_cmp++; if (rsp_valid !== exp || rsp_data !== exp_d) begin n_bad++; $display("FAIL fp_rsp cyc%0d: got %b/%h want %b/%h", i, rsp_valid, rsp_data, exp, exp_d); end
      end else begin
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL fp_rsp_quiet cyc%0d: got %b want 00", i, rsp_valid); end
      end
      req_valid = (i < 4) ? 2'b11 : ((i == 4) ? 2'b10 : 2'b00);
      #1;
      if (i <= 4) begin
        exp = (i < 4) ? 2'b01 : 2'b10;
        n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL fp_grant cyc%0d: got %b want %b", i, req_ready, exp); end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    req_col = {10'h123, 10'h030};
    req_row = {10'h045, 10'h003};
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_issue0: got %b want 01", req_ready); end
    cyc();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_issue1: got %b want 01", req_ready); end
    cyc();
    reset = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rsp_c2: got %b want 00", rsp_valid); end
    cyc();
    reset = 1'b0;
    req_valid = 2'b00;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %b want 1", idle); end
    n_cmp++; if (map_col !== 10'h000 || map_row !== 10'h000) begin n_bad++; $display("FAIL mid_map_addr: got %h/%h want 000/000", map_col, map_row); end
    for (int i = 3; i <= 6; i++) begin
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_no_rsp cyc%0d: got %b want 00", i, rsp_valid); end
      cyc();
    end
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_ptr_restart: got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    for (int j = 1; j <= 4; j++) begin
      if (j == 3) begin
        n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h33) begin n_bad++; $display("FAIL mid_after_rsp: got %b/%h want 01/33", rsp_valid, rsp_data); end
      end
      cyc();
    end
  endtask

  task automatic test_latency3();
    req_col_l3[9:0] = 10'h055;
    req_row_l3[9:0] = 10'h00A;
    req_valid_l3 = 2'b01;
    #1;
    n_cmp++; if (req_ready_l3 !== 2'b01) begin n_bad++; $display("FAIL l3_ready: got %b want 01", req_ready_l3); end
    for (int i = 1; i <= 7; i++) begin
      cyc();
      req_valid_l3 = 2'b00;
      n_cmp++;
      if (rsp_valid_l3 !== ((i == 5) ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL l3_rsp_timing cyc%0d: got %b", i, rsp_valid_l3);
      end
      if (i == 5) begin
        n_cmp++; if (rsp_data_l3 !== 8'h5F) begin n_bad++; $display("FAIL l3_rsp_data: got %h want 5f", rsp_data_l3); end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_col      = '0;
    req_row      = '0;
    req_valid_l3 = '0;
    req_col_l3   = '0;
    req_row_l3   = '0;
    test_reset();
    test_single();
    test_req1_pixel();
`ifdef MAP_ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_reset_mid();
    test_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
